// File: rtl/cuenta_ctrl_if.sv
// Signal bundle between the event-counter sequencer and its environment.
// master drives raw event, commands and counter value; slave drives strobes, status and scan.
interface cuenta_ctrl_if;
    logic        evento;
    logic        start;
    logic        stop;
    logic        clear;
    logic        lap;
    logic [15:0] digits_in;
    logic        cnt_inc;
    logic        cnt_clr;
    logic        running;
    logic        overflow;
    logic        lap_active;
    logic [3:0]  disp_sel;
    logic [3:0]  disp_digit;

    modport master (
        output evento, start, stop, clear, lap, digits_in,
        input  cnt_inc, cnt_clr, running, overflow, lap_active, disp_sel, disp_digit
    );

    modport slave (
        input  evento, start, stop, clear, lap, digits_in,
        output cnt_inc, cnt_clr, running, overflow, lap_active, disp_sel, disp_digit
    );
endinterface

// File: rtl/cuenta_ctrl.sv
// Run-state sequencer for the 4-digit BCD counter with lap freeze and 7-seg digit scan.
// Latency: evento to cnt_inc 3 clk, command level to state/cnt_clr 2 clk; no backpressure, events outside RUN are dropped.
module cuenta_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic         clk,
    input  logic         reset,
    cuenta_ctrl_if.slave bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int C_START = 0;
    localparam int C_STOP  = 1;
    localparam int C_CLEAR = 2;
    localparam int C_LAP   = 3;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_t;

    state_t             state_q, state_d;
    logic               ev_s1_q, ev_s2_q, ev_d_q;
    logic [3:0]         cmd_q, cmd_prev_q;
    logic               cnt_inc_q, cnt_inc_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic               running_q, running_d;
    logic               overflow_q, overflow_d;
    logic               lap_active_q, lap_active_d;
    logic [15:0]        disp_reg_q, disp_reg_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         disp_sel_q, disp_sel_d;
    logic [3:0]         disp_digit_q, disp_digit_d;
    logic               ev_rise;
    logic [3:0]         cmd_edge;

    always_comb begin
        ev_rise   = ev_s2_q & ~ev_d_q;
        cmd_edge  = cmd_q & ~cmd_prev_q;
        state_d   = state_q;
        cnt_inc_d = 1'b0;
        cnt_clr_d = 1'b0;

        // clear beats stop beats start; an event only counts when nothing else moves the state
        if (cmd_edge[C_CLEAR]) begin
            state_d   = IDLE;
            cnt_clr_d = 1'b1;
        end else begin
            case (state_q)
                IDLE:  if (cmd_edge[C_START]) state_d = RUN;
                RUN: begin
                    if (cmd_edge[C_STOP]) begin
                        state_d = PAUSE;
                    end else if (ev_rise) begin
                        if (bus.digits_in == 16'h9999) state_d = FULL;
                        else                           cnt_inc_d = 1'b1;
                    end
                end
                PAUSE: if (cmd_edge[C_START]) state_d = RUN;
                FULL:  state_d = FULL;
                default: state_d = IDLE;
            endcase
        end

        running_d    = (state_d == RUN);
        overflow_d   = (state_d == FULL);
        lap_active_d = cmd_edge[C_CLEAR] ? 1'b0 : (lap_active_q ^ cmd_edge[C_LAP]);
        disp_reg_d   = lap_active_q ? disp_reg_q : bus.digits_in;

        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
        disp_sel_d   = 4'b0001 << idx_d;
        disp_digit_d = disp_reg_q[{idx_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ev_s1_q      <= 1'b0;
            ev_s2_q      <= 1'b0;
            ev_d_q       <= 1'b0;
            cmd_q        <= '0;
            cmd_prev_q   <= '0;
            cnt_inc_q    <= 1'b0;
            cnt_clr_q    <= 1'b0;
            running_q    <= 1'b0;
            overflow_q   <= 1'b0;
            lap_active_q <= 1'b0;
            disp_reg_q   <= '0;
            div_q        <= '0;
            idx_q        <= '0;
            disp_sel_q   <= 4'b0001;
            disp_digit_q <= '0;
        end else begin
            state_q      <= state_d;
            ev_s1_q      <= bus.evento;
            ev_s2_q      <= ev_s1_q;
            ev_d_q       <= ev_s2_q;
            cmd_q        <= {bus.lap, bus.clear, bus.stop, bus.start};
            cmd_prev_q   <= cmd_q;
            cnt_inc_q    <= cnt_inc_d;
            cnt_clr_q    <= cnt_clr_d;
            running_q    <= running_d;
            overflow_q   <= overflow_d;
            lap_active_q <= lap_active_d;
            disp_reg_q   <= disp_reg_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            disp_sel_q   <= disp_sel_d;
            disp_digit_q <= disp_digit_d;
        end
    end

    assign bus.cnt_inc    = cnt_inc_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.running    = running_q;
    assign bus.overflow   = overflow_q;
    assign bus.lap_active = lap_active_q;
    assign bus.disp_sel   = disp_sel_q;
    assign bus.disp_digit = disp_digit_q;
endmodule

// File: tb/tb_cuenta_ctrl.sv
// Bench for cuenta_ctrl: transaction-level model predicts strobes into a queue, a negedge monitor pops them.
// Also emulates the external BCD counter so digits_in follows the strobes.
module tb_cuenta_ctrl;
    localparam int SCAN = 4;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_FULL} mst_t;
    typedef struct { bit clr; int cyc; } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld = 1'b0;
    logic [15:0] ld_val = '0;
    logic [15:0] ctr = '0;
    int          cyc = 0;
    int          r0 = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    mst_t        mstate = M_IDLE;
    int          mcount = 0;
    bit          mlap = 1'b0;

    cuenta_ctrl_if bus ();

    cuenta_ctrl #(.SCAN_DIV(SCAN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    // external counter: reacts to strobes one edge later, can be preloaded
    always @(posedge clk) begin
        if (bus.cnt_clr)      ctr <= '0;
        else if (bus.cnt_inc) ctr <= to_bcd((from_bcd(ctr) + 1) % 10000);
        else if (ld)          ctr <= ld_val;
    end
    assign bus.digits_in = ctr;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cnt_inc || bus.cnt_clr) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL strobe_unexpected: inc=%0b clr=%0b at cyc %0d, expected none",
                             bus.cnt_inc, bus.cnt_clr, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind", {bus.cnt_clr, bus.cnt_inc}, mon_e.clr ? 2 : 1);
                    chk("strobe_cycle", cyc, mon_e.cyc);
                end
            end
            if (cyc > r0) chk("disp_sel", bus.disp_sel, 1 << (((cyc - r0) / SCAN) % 4));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit clr, input int c);
        exp_t e;
        e.clr = clr;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic op_event();
        int k;
        k = cyc;
        bus.evento = 1'b1;
        if (mstate == M_RUN) begin
            if (mcount == 9999) mstate = M_FULL;
            else begin
                push(1'b0, k + 3);
                mcount++;
            end
        end
        tick(2);
        bus.evento = 1'b0;
        tick(2);
    endtask

    task automatic model_cmd(input int which, input int k);
        case (which)
            0: if (mstate == M_IDLE || mstate == M_PAUSE) mstate = M_RUN;
            1: if (mstate == M_RUN) mstate = M_PAUSE;
            2: begin
                mstate = M_IDLE;
                mcount = 0;
                mlap   = 1'b0;
                push(1'b1, k);
            end
            default: mlap = ~mlap;
        endcase
    endtask

    task automatic op_cmd(input int which);
        int k;
        k = cyc;
        case (which)
            0: bus.start = 1'b1;
            1: bus.stop  = 1'b1;
            2: bus.clear = 1'b1;
            default: bus.lap = 1'b1;
        endcase
        model_cmd(which, k + 2);
        tick(2);
        {bus.start, bus.stop, bus.clear, bus.lap} = '0;
        tick(2);
    endtask

    task automatic op_load(input int v);
        ld_val = to_bcd(v);
        ld     = 1'b1;
        tick(1);
        ld     = 1'b0;
        mcount = v;
        tick(2);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_running"}, bus.running, mstate == M_RUN);
        chk({tag, "_overflow"}, bus.overflow, mstate == M_FULL);
        chk({tag, "_lap_active"}, bus.lap_active, mlap);
        chk({tag, "_count"}, ctr, to_bcd(mcount));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cnt_inc"}, bus.cnt_inc, 0);
        chk({tag, "_cnt_clr"}, bus.cnt_clr, 0);
        chk({tag, "_running"}, bus.running, 0);
        chk({tag, "_overflow"}, bus.overflow, 0);
        chk({tag, "_lap_active"}, bus.lap_active, 0);
        chk({tag, "_disp_sel"}, bus.disp_sel, 1);
        chk({tag, "_disp_digit"}, bus.disp_digit, 0);
    endtask

    task automatic check_scan(input string tag, input logic [15:0] shown);
        int idx;
        for (int i = 0; i < 4 * SCAN; i++) begin
            tick(1);
            idx = ((cyc - r0) / SCAN) % 4;
            chk(tag, bus.disp_digit, int'((shown >> (4 * idx)) & 16'hF));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int op;
        int v;
        {bus.evento, bus.start, bus.stop, bus.clear, bus.lap} = '0;
        tick(3);
        check_reset_vals("por");
        #1 reset = 1'b0;
        r0 = cyc;
        tick(2);

        // start then 12 events at 4-clk spacing
        op_cmd(0);
        for (int i = 0; i < 12; i++) op_event();
        check_status("run12");

        // events while paused are dropped
        op_cmd(1);
        check_status("paused");
        for (int i = 0; i < 5; i++) op_event();
        op_cmd(0);
        for (int i = 0; i < 3; i++) op_event();
        check_status("resumed");

        // terminal count
        op_load(9998);
        for (int i = 0; i < 3; i++) op_event();
        check_status("full");
        op_cmd(0);
        check_status("full_start");
        op_cmd(2);
        check_status("full_clear");

        // clear+stop+start together with an event in the same decision cycle
        op_cmd(0);
        k = cyc;
        bus.evento = 1'b1;
        tick(1);
        {bus.clear, bus.stop, bus.start} = 3'b111;
        model_cmd(2, k + 3);
        tick(1);
        bus.evento = 1'b0;
        tick(1);
        {bus.clear, bus.stop, bus.start} = 3'b000;
        tick(4);
        check_status("coincide");

        // lap freeze on the scan
        op_load(1234);
        op_cmd(3);
        op_load(5678);
        check_status("lap_on");
        check_scan("scan_frozen", 16'h1234);
        op_cmd(3);
        tick(1);
        check_scan("scan_live", 16'h5678);

        // reset while cnt_inc is high
        op_cmd(0);
        k = cyc;
        bus.evento = 1'b1;
        push(1'b0, k + 3);
        tick(3);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("rst_cut");
        bus.evento = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_reset_vals("rst_hold");
        end
        #1 reset = 1'b0;
        r0 = cyc;
        mstate = M_IDLE;
        mlap   = 1'b0;
        tick(2);
        check_status("after_rst");

        // randomized operations
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) op_event();
            else if (op == 4) op_cmd(0);
            else if (op == 5) op_cmd(1);
            else if (op == 6) op_cmd(2);
            else if (op == 7) op_cmd(3);
            else begin
                if ($urandom_range(0, 2) == 0) v = $urandom_range(9997, 9999);
                else v = $urandom_range(0, 9999);
                op_load(v);
            end
            check_status("rand");
        end

        tick(8);
        chk("pending_strobes", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
